// File: rtl/fifo_pkg.sv
// Shared types and the occupancy-flag decode for the descriptor FIFO.
package fifo_pkg;

    typedef struct packed {
        logic full;
        logic empty;
        logic half_full;
        logic almost_full;
        logic almost_empty;
    } fifo_flags_t;

    function automatic fifo_flags_t decode_flags(
        input int unsigned count,
        input int unsigned depth,
        input int unsigned af_margin,
        input int unsigned ae_margin
    );
        fifo_flags_t f;
        f.full         = (count == depth);
        f.empty        = (count == 0);
        f.half_full    = (count >= depth / 2);
        f.almost_full  = (count >= depth - af_margin);
        f.almost_empty = (count <= ae_margin);
        return f;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x WIDTH storage: synchronous write port, asynchronous read port.
module fifo_mem #(
    parameter int unsigned WIDTH = 96,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Contents are deliberately never reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fifo.sv
// First-word-fall-through FIFO holding in-flight depth-fetch descriptors.
module fifo
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH     = 96,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned AF_MARGIN = 2,
    parameter int unsigned AE_MARGIN = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             wr,
    input  logic             rd,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic             half_full,
    output logic             almost_full,
    output logic             almost_empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_wr, do_rd;
    fifo_flags_t   flags;

    assign flags = decode_flags(32'(count_q), DEPTH, AF_MARGIN, AE_MARGIN);

    assign full         = flags.full;
    assign empty        = flags.empty;
    assign half_full    = flags.half_full;
    assign almost_full  = flags.almost_full;
    assign almost_empty = flags.almost_empty;

    // A pop while full frees the slot being written, so the push still lands.
    assign do_wr = wr && (!full || rd);
    assign do_rd = rd && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_wr) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (do_rd) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        if (do_wr && !do_rd) begin
            count_d = count_q + CNT_ONE;
        end else if (do_rd && !do_wr) begin
            count_d = count_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .we_i    (do_wr && reset),
        .waddr_i (wr_ptr_q),
        .wdata_i (din),
        .raddr_i (rd_ptr_q),
        .rdata_o (dout)
    );

endmodule

// File: tb/tb_fifo.sv
// Directed and scoreboard-checked bench for the descriptor FIFO.
module tb_fifo;

    localparam int W = 96;
    localparam int D = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] din;
    logic         wr;
    logic         rd;
    logic [W-1:0] dout;
    logic         full, empty, half_full, almost_full, almost_empty;

    int total = 0;
    int bad   = 0;
    logic [W-1:0] q[$];

    fifo #(.WIDTH(W), .DEPTH(D), .AF_MARGIN(2), .AE_MARGIN(1)) dut (
        .clk          (clk),
        .reset        (reset),
        .din          (din),
        .wr           (wr),
        .rd           (rd),
        .dout         (dout),
        .full         (full),
        .empty        (empty),
        .half_full    (half_full),
        .almost_full  (almost_full),
        .almost_empty (almost_empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    // flags packed as {full, empty, half_full, almost_full, almost_empty}
    function automatic logic [4:0] model_flags(input int c);
        return {c == 16, c == 0, c >= 8, c >= 14, c <= 1};
    endfunction

    task automatic check_state(input string tag);
        chk({tag, "_flags"}, W'({full, empty, half_full, almost_full, almost_empty}),
            W'(model_flags(q.size())));
        chk({tag, "_count"}, W'(dut.count_q), W'(q.size()));
        if (q.size() != 0) chk({tag, "_head"}, dout, q[0]);
    endtask

    task automatic cyc(input logic w, input logic r, input logic [W-1:0] d);
        logic mw, mr;
        wr  = w;
        rd  = r;
        din = d;
        mr  = r && (q.size() != 0);
        mw  = w && (q.size() != D || r);
        if (mr) chk("pop_dout", dout, q[0]);
        @(posedge clk);
        #1;
        if (mr) void'(q.pop_front());
        if (mw) q.push_back(d);
        wr = 1'b0;
        rd = 1'b0;
        check_state("cyc");
    endtask

    task automatic do_reset(input logic w, input logic [W-1:0] d);
        reset = 1'b0;
        wr    = w;
        rd    = 1'b0;
        din   = d;
        @(posedge clk);
        #1;
        reset = 1'b1;
        wr    = 1'b0;
        q.delete();
    endtask

    initial begin
        reset = 1'b0;
        wr    = 1'b0;
        rd    = 1'b0;
        din   = '0;
        do_reset(1'b0, '0);
        @(posedge clk);
        #1;
        chk("rst_flags", W'({full, empty, half_full, almost_full, almost_empty}), W'(5'b01001));
        chk("rst_count", W'(dut.count_q), W'(0));

        for (int i = 1; i <= 16; i++) begin
            cyc(1'b1, 1'b0, W'(i));
            if (i == 7)  chk("hf_at7", W'(half_full), W'(0));
            if (i == 8)  chk("hf_at8", W'(half_full), W'(1));
            if (i == 13) chk("af_at13", W'(almost_full), W'(0));
            if (i == 14) chk("af_at14", W'(almost_full), W'(1));
            if (i == 15) chk("full_at15", W'(full), W'(0));
            if (i == 16) chk("full_at16", W'(full), W'(1));
        end
        cyc(1'b1, 1'b0, W'('hDEAD));
        chk("ovf_count", W'(dut.count_q), W'(16));
        chk("ovf_head", dout, W'(1));
        for (int i = 1; i <= 16; i++) begin
            chk("drain_seq", dout, W'(i));
            cyc(1'b0, 1'b1, '0);
        end
        chk("drain_empty", W'(empty), W'(1));

        cyc(1'b1, 1'b0, W'('hABC));
        chk("fwft_empty", W'(empty), W'(0));
        chk("fwft_dout", dout, W'('hABC));
        cyc(1'b0, 1'b1, '0);
        chk("fwft_pop_empty", W'(empty), W'(1));

        for (int i = 1; i <= 16; i++) cyc(1'b1, 1'b0, W'('h100 + i));
        cyc(1'b1, 1'b1, W'('h55));
        chk("fullrw_count", W'(dut.count_q), W'(16));
        chk("fullrw_head", dout, W'('h102));
        for (int i = 0; i < 15; i++) cyc(1'b0, 1'b1, '0);
        chk("fullrw_last", dout, W'('h55));
        cyc(1'b0, 1'b1, '0);
        chk("fullrw_empty", W'(empty), W'(1));

        for (int i = 0; i < 100; i++) begin
            cyc(1'($urandom % 2), 1'($urandom % 2), {$urandom, $urandom, $urandom});
        end
        while (q.size() != 0) cyc(1'b0, 1'b1, '0);

        cyc(1'b0, 1'b1, '0);
        chk("udf_count", W'(dut.count_q), W'(0));
        chk("udf_wrptr", W'(dut.wr_ptr_q), W'(dut.rd_ptr_q));
        cyc(1'b1, 1'b1, W'('h3C));
        chk("empty_wr_rd_count", W'(dut.count_q), W'(1));
        chk("empty_wr_rd_dout", dout, W'('h3C));
        cyc(1'b0, 1'b1, '0);

        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, W'('h200 + i));
        do_reset(1'b1, W'('hBAD));
        chk("mid_rst_empty", W'(empty), W'(1));
        chk("mid_rst_count", W'(dut.count_q), W'(0));
        check_state("mid_rst");
        cyc(1'b1, 1'b0, W'('h77));
        chk("post_rst_dout", dout, W'('h77));
        cyc(1'b0, 1'b1, '0);
        chk("post_rst_empty", W'(empty), W'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
